// File: rtl/ramp_gen_pkg.sv
// Shared types and constants for the multi-channel ramp generator.
package ramp_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_FREE    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

   localparam int WRAP_W = 16;

endpackage

// File: rtl/ramp_gen_chan.sv
// One ramp channel: start/stop FSM, stepped counter with terminal pulse.
// Optional terminal-event counter under RAMP_GEN_WRAPCNT_EN.
module ramp_gen_chan
   import ramp_gen_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trig,
   input  logic              start,
   input  logic              stop,
   input  logic              mode,
   input  logic [WIDTH-1:0]  ref_cnt,
   input  logic [STEP_W-1:0] step,
   output logic [WIDTH-1:0]  data_out,
   output logic              tc,
   output logic              busy
`ifdef RAMP_GEN_WRAPCNT_EN
   ,
   output logic [WRAP_W-1:0] wrap_cnt
`endif
);

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  cnt_nxt;
   logic              tc_nxt;
   logic [STEP_W-1:0] eff_step;
   logic [WIDTH:0]    sum;
   logic              term;

   // The extra sum bit catches a step that would carry past 2^WIDTH; that is a terminal event.
   assign eff_step = (step == '0) ? STEP_W'(1) : step;
   assign sum      = {1'b0, data_out} + (WIDTH+1)'(eff_step);
   assign term     = (data_out >= ref_cnt) || sum[WIDTH];

   // NOTE: non-blocking assignments for every register so all flops update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         data_out <= '0;
         tc       <= 1'b0;
      end else begin
         state    <= state_nxt;
         data_out <= cnt_nxt;
         tc       <= tc_nxt;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = data_out;
      tc_nxt    = 1'b0;
      if (stop) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else if (start) begin
         state_nxt = RUN;
         cnt_nxt   = '0;
      end else if (state == RUN && trig) begin
         if (term) begin
            cnt_nxt   = '0;
            tc_nxt    = 1'b1;
            state_nxt = (mode == MODE_ONESHOT) ? DONE : RUN;
         end else begin
            cnt_nxt = sum[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      busy = (state == RUN);
   end

`ifdef RAMP_GEN_WRAPCNT_EN
   // Survives stop so the number of completed ramps can be read afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrap_cnt <= '0;
      end else if (start && !stop) begin
         wrap_cnt <= '0;
      end else if (tc_nxt) begin
         wrap_cnt <= wrap_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: rtl/ramp_gen_mc.sv
// NCH independent ramp channels sharing one clock and reset.
// Define RAMP_GEN_WRAPCNT_EN to add the per-channel wrap_cnt output.
module ramp_gen_mc
   import ramp_gen_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NCH    = 4,
   parameter int STEP_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NCH-1:0]        trig,
   input  logic [NCH-1:0]        start,
   input  logic [NCH-1:0]        stop,
   input  logic [NCH-1:0]        mode,
   input  logic [NCH*WIDTH-1:0]  ref_cnt,
   input  logic [NCH*STEP_W-1:0] step,
   output logic [NCH*WIDTH-1:0]  data_out,
   output logic [NCH-1:0]        tc,
   output logic [NCH-1:0]        busy
`ifdef RAMP_GEN_WRAPCNT_EN
   ,
   output logic [NCH*WRAP_W-1:0] wrap_cnt
`endif
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      ramp_gen_chan #(
         .WIDTH  (WIDTH),
         .STEP_W (STEP_W)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .trig     (trig[i]),
         .start    (start[i]),
         .stop     (stop[i]),
         .mode     (mode[i]),
         .ref_cnt  (ref_cnt[i*WIDTH +: WIDTH]),
         .step     (step[i*STEP_W +: STEP_W]),
         .data_out (data_out[i*WIDTH +: WIDTH]),
         .tc       (tc[i]),
         .busy     (busy[i])
`ifdef RAMP_GEN_WRAPCNT_EN
         ,
         .wrap_cnt (wrap_cnt[i*WRAP_W +: WRAP_W])
`endif
      );
   end

endmodule

// File: tb/tb_ramp_gen_mc.sv
// Scoreboard bench for ramp_gen_mc: driver pushes model predictions, monitor pops and compares.
module tb_ramp_gen_mc;
   localparam int WIDTH  = 8;
   localparam int NCH    = 4;
   localparam int STEP_W = 8;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic [NCH-1:0]        trig = '0, start = '0, stop = '0, mode = '0;
   logic [NCH*WIDTH-1:0]  ref_cnt = '0;
   logic [NCH*STEP_W-1:0] step = '0;
   logic [NCH*WIDTH-1:0]  data_out;
   logic [NCH-1:0]        tc, busy;
`ifdef RAMP_GEN_WRAPCNT_EN
   logic [NCH*16-1:0]     wrap_cnt;
`endif

   ramp_gen_mc #(.WIDTH(WIDTH), .NCH(NCH), .STEP_W(STEP_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .trig     (trig),
      .start    (start),
      .stop     (stop),
      .mode     (mode),
      .ref_cnt  (ref_cnt),
      .step     (step),
      .data_out (data_out),
      .tc       (tc),
      .busy     (busy)
`ifdef RAMP_GEN_WRAPCNT_EN
      ,
      .wrap_cnt (wrap_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NCH*WIDTH-1:0] d;
      logic [NCH-1:0]       tc;
      logic [NCH-1:0]       busy;
      logic [NCH*16-1:0]    w;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Behavioural model: a channel is either running or not; DONE and IDLE look alike from outside.
   int   m_cnt [NCH];
   bit   m_run [NCH];
   int   m_wrap[NCH];
   int   nxt_ref [NCH];
   int   nxt_step[NCH];
   bit   nxt_mode[NCH];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_cnt[i] = 0; m_run[i] = 0; m_wrap[i] = 0;
      end
   endtask

   // Applies inputs for the coming edge and pushes what that edge must produce.
   task automatic cycle(input logic [NCH-1:0] t, input logic [NCH-1:0] s, input logic [NCH-1:0] p);
      exp_t e;
      int   eff;
      @(posedge clk);
      #2;
      trig = t; start = s; stop = p;
      e.tc = '0; e.busy = '0; e.d = '0; e.w = '0;
      for (int i = 0; i < NCH; i++) begin
         mode[i] = nxt_mode[i];
         ref_cnt[i*WIDTH +: WIDTH] = WIDTH'(nxt_ref[i]);
         step[i*STEP_W +: STEP_W]  = STEP_W'(nxt_step[i]);
         eff = (nxt_step[i] == 0) ? 1 : nxt_step[i];
         if (p[i]) begin
            m_run[i] = 0; m_cnt[i] = 0;
         end else if (s[i]) begin
            m_run[i] = 1; m_cnt[i] = 0; m_wrap[i] = 0;
         end else if (m_run[i] && t[i]) begin
            if (m_cnt[i] >= nxt_ref[i] || m_cnt[i] + eff >= (1 << WIDTH)) begin
               m_cnt[i] = 0;
               e.tc[i] = 1'b1;
               m_wrap[i] = (m_wrap[i] + 1) % 65536;
               if (nxt_mode[i]) m_run[i] = 0;
            end else begin
               m_cnt[i] = m_cnt[i] + eff;
            end
         end
         e.busy[i] = m_run[i];
         e.d[i*WIDTH +: WIDTH] = WIDTH'(m_cnt[i]);
         e.w[i*16 +: 16] = 16'(m_wrap[i]);
      end
      q.push_back(e);
   endtask

   task automatic set_ch(input int ch, input bit md, input int rf, input int st);
      nxt_mode[ch] = md; nxt_ref[ch] = rf; nxt_step[ch] = st;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("data_out", 64'(data_out), 64'(e.d));
            check("tc", 64'(tc), 64'(e.tc));
            check("busy", 64'(busy), 64'(e.busy));
`ifdef RAMP_GEN_WRAPCNT_EN
            check("wrap_cnt", 64'(wrap_cnt), 64'(e.w));
`endif
         end
      end
   end

   initial begin : driver
      logic [NCH-1:0] rs, rp;
      model_reset();
      for (int i = 0; i < NCH; i++) set_ch(i, 1'b0, 0, 1);
      #12;
      check("reset_data", 64'(data_out), 64'd0);
      check("reset_tc", 64'(tc), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;

      // Free-run ramp 0..3 with start+trig in the same cycle.
      set_ch(0, 1'b0, 3, 1);
      cycle(4'b0001, 4'b0001, 4'b0000);
      for (int k = 0; k < 12; k++) cycle(4'b0001, 4'b0000, 4'b0000);

      // One-shot ramp by 4 to 10, ticking every other cycle, then idle ticks in DONE.
      set_ch(1, 1'b1, 10, 4);
      cycle(4'b0000, 4'b0010, 4'b0000);
      for (int k = 0; k < 16; k++) cycle((k % 2) ? 4'b0010 : 4'b0000, 4'b0000, 4'b0000);
      cycle(4'b0000, 4'b0000, 4'b0011);

      // Carry out of WIDTH bits is terminal.
      set_ch(2, 1'b0, 255, 200);
      cycle(4'b0000, 4'b0100, 4'b0000);
      for (int k = 0; k < 4; k++) cycle(4'b0100, 4'b0000, 4'b0000);

      // Stop+start together at count 5, then start with trig, then run to 7.
      set_ch(3, 1'b0, 100, 1);
      cycle(4'b0000, 4'b1000, 4'b0000);
      for (int k = 0; k < 5; k++) cycle(4'b1000, 4'b0000, 4'b0000);
      cycle(4'b0000, 4'b1000, 4'b1000);
      cycle(4'b1000, 4'b1000, 4'b0000);
      for (int k = 0; k < 7; k++) cycle(4'b1000, 4'b0000, 4'b0000);

      // Asynchronous reset between edges.
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("async_reset_data", 64'(data_out), 64'd0);
      check("async_reset_tc", 64'(tc), 64'd0);
      check("async_reset_busy", 64'(busy), 64'd0);
      trig = '0; start = '0; stop = '0;
      model_reset();
      @(posedge clk);
      #2;
      reset = 1'b0;

      // step=0 counts by one.
      set_ch(3, 1'b0, 100, 0);
      cycle(4'b0000, 4'b1000, 4'b0000);
      for (int k = 0; k < 4; k++) cycle(4'b1000, 4'b0000, 4'b0000);

      // ref_cnt=0 gives tc on every tick.
      set_ch(0, 1'b0, 0, 1);
      cycle(4'b0000, 4'b0001, 4'b0000);
      for (int k = 0; k < 5; k++) cycle(4'b0001, 4'b0000, 4'b0000);

      // Lowering ref_cnt below the count terminates on the next tick.
      set_ch(1, 1'b0, 50, 3);
      cycle(4'b0000, 4'b0010, 4'b0000);
      for (int k = 0; k < 6; k++) cycle(4'b0010, 4'b0000, 4'b0000);
      nxt_ref[1] = 5;
      for (int k = 0; k < 3; k++) cycle(4'b0010, 4'b0000, 4'b0000);

      // Stop coinciding with a terminal tick suppresses tc.
      set_ch(2, 1'b0, 2, 1);
      cycle(4'b0000, 4'b0100, 4'b0000);
      for (int k = 0; k < 2; k++) cycle(4'b0100, 4'b0000, 4'b0000);
      cycle(4'b0100, 4'b0000, 4'b0100);
      cycle(4'b0100, 4'b0000, 4'b0000);

      // Randomised traffic with live parameter changes.
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            for (int i = 0; i < NCH; i++) begin
               nxt_mode[i] = 1'($urandom_range(0, 1));
               nxt_ref[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(200, 255))
                                                         : int'($urandom_range(0, 20));
               nxt_step[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
               if ($urandom_range(0, 1) == 0) nxt_step[i] = int'($urandom_range(1, 4));
            end
         end
         for (int i = 0; i < NCH; i++) begin
            rs[i] = ($urandom_range(0, 15) == 0);
            rp[i] = ($urandom_range(0, 31) == 0);
         end
         cycle(NCH'($urandom), rs, rp);
      end

`ifdef RAMP_GEN_WRAPCNT_EN
      // Terminal counter rolls over 0xFFFF and is cleared by start.
      for (int i = 0; i < NCH; i++) set_ch(i, 1'b0, 0, 1);
      cycle(4'b0000, 4'b0001, 4'b1110);
      for (int k = 0; k < 65537; k++) cycle(4'b0001, 4'b0000, 4'b0000);
      cycle(4'b0000, 4'b0000, 4'b0001);
      cycle(4'b0000, 4'b0001, 4'b0000);
`endif

      @(posedge clk);
      @(posedge clk);
      #3;
      check("queue_drained", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
